// File: rtl/spi_reg_access.sv
// spi_reg_access: turns a host register read/write request into one 2-byte
// SPI chip-select frame {rw, addr} + {wdata | dummy}. The byte the slave
// returns in the second slot comes back as the response data. If the frame
// does not finish within TIMEOUT_CLKS clocks, the request ends with an error.
module spi_reg_access #(
    parameter int          TIMEOUT_CLKS = 1024,
    parameter logic [7:0]  DUMMY_BYTE   = 8'h00,
    parameter int          CNT_W        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_Req_Valid,
    input  logic             i_Req_RW,
    input  logic [6:0]       i_Req_Addr,
    input  logic [7:0]       i_Req_WData,
    output logic             o_Req_Ready,
    output logic             o_Resp_Valid,
    output logic [7:0]       o_Resp_RData,
    output logic             o_Resp_Err,
    output logic [CNT_W-1:0] o_TX_Count,
    output logic [7:0]       o_TX_Byte,
    output logic             o_TX_En,
    input  logic             i_TX_Ready,
    input  logic [CNT_W-1:0] i_RX_Count,
    input  logic [7:0]       i_RX_Byte,
    input  logic             i_RX_En
);

    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(2);

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, HOLD, SEND_DATA, WAIT_RX, DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [7:0]       cmd_reg, cmd_next;
    logic [7:0]       data_reg, data_next;

    logic             ready_next;
    logic             resp_valid_next;
    logic [7:0]       rdata_next;
    logic             err_next;
    logic [CNT_W-1:0] tx_count_next;
    logic [7:0]       tx_byte_next;
    logic             tx_en_next;

    logic timeout;
    logic capture;

    // Timeout fires only on the last allowed cycle; a second-slot capture in
    // that same cycle still counts as a normal completion.
    assign timeout = (tmr_reg == TMR_LAST);
    assign capture = (state_reg == WAIT_RX) && i_RX_En && (i_RX_Count == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (i_Req_Valid) state_next = SEND_CMD;
            SEND_CMD:  if (timeout) state_next = DONE;
                       else if (i_TX_Ready) state_next = HOLD;
            HOLD:      if (timeout) state_next = DONE;
                       else state_next = SEND_DATA;
            SEND_DATA: if (timeout) state_next = DONE;
                       else if (i_TX_Ready) state_next = WAIT_RX;
            WAIT_RX:   if (capture || timeout) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs, timer and latched request
    always_comb begin
        ready_next      = (state_next == IDLE);
        resp_valid_next = (state_next == DONE);
        rdata_next      = o_Resp_RData;
        err_next        = o_Resp_Err;
        tx_count_next   = o_TX_Count;
        tx_byte_next    = o_TX_Byte;
        tx_en_next      = 1'b0;
        tmr_next        = tmr_reg;
        cmd_next        = cmd_reg;
        data_next       = data_reg;

        case (state_reg)
            IDLE: begin
                if (i_Req_Valid) begin
                    cmd_next  = {i_Req_RW, i_Req_Addr};
                    data_next = i_Req_RW ? DUMMY_BYTE : i_Req_WData;
                    tmr_next  = '0;
                end
            end
            SEND_CMD, HOLD, SEND_DATA, WAIT_RX: begin
                if (tmr_reg != TMR_MAX) tmr_next = tmr_reg + 1'b1;
            end
            default: ;
        endcase

        if (state_reg == SEND_CMD && !timeout && i_TX_Ready) begin
            tx_en_next    = 1'b1;
            tx_byte_next  = cmd_reg;
            tx_count_next = FRAME_LEN;
        end
        if (state_reg == SEND_DATA && !timeout && i_TX_Ready) begin
            tx_en_next    = 1'b1;
            tx_byte_next  = data_reg;
            tx_count_next = FRAME_LEN;
        end

        if (capture) begin
            rdata_next = i_RX_Byte;
            err_next   = 1'b0;
        end else if (timeout && state_reg != IDLE && state_reg != DONE) begin
            rdata_next = 8'h00;
            err_next   = 1'b1;
        end
    end

    // Output, timer and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_Req_Ready  <= 1'b1;
            o_Resp_Valid <= 1'b0;
            o_Resp_RData <= 8'h00;
            o_Resp_Err   <= 1'b0;
            o_TX_Count   <= '0;
            o_TX_Byte    <= 8'h00;
            o_TX_En      <= 1'b0;
            tmr_reg      <= '0;
            cmd_reg      <= 8'h00;
            data_reg     <= 8'h00;
        end else begin
            o_Req_Ready  <= ready_next;
            o_Resp_Valid <= resp_valid_next;
            o_Resp_RData <= rdata_next;
            o_Resp_Err   <= err_next;
            o_TX_Count   <= tx_count_next;
            o_TX_Byte    <= tx_byte_next;
            o_TX_En      <= tx_en_next;
            tmr_reg      <= tmr_next;
            cmd_reg      <= cmd_next;
            data_reg     <= data_next;
        end
    end

endmodule

// File: tb/tb_spi_reg_access.sv
// Bench for spi_reg_access: a small SPI master/slave model answers each frame.
// Directed vectors cover reads and writes; hand sequences cover timeout,
// capture/timeout collision, busy drop, reset mid-frame and back-to-back.
module tb_spi_reg_access;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_Req_Valid = 1'b0;
    logic       i_Req_RW = 1'b0;
    logic [6:0] i_Req_Addr = '0;
    logic [7:0] i_Req_WData = '0;
    logic       o_Req_Ready, o_Resp_Valid, o_Resp_Err, o_TX_En;
    logic [7:0] o_Resp_RData, o_TX_Byte;
    logic [1:0] o_TX_Count;
    logic       i_TX_Ready, i_RX_En;
    logic [1:0] i_RX_Count;
    logic [7:0] i_RX_Byte;

    // SPI model drive and manual overrides
    logic       model_rdy = 1'b1, block_rdy = 1'b0;
    logic       model_rx_en = 1'b0, man_rx_en = 1'b0;
    logic [1:0] model_cnt = '0, man_cnt = '0;
    logic [7:0] model_byte = '0, man_byte = '0;
    logic       model_en = 1'b1, echo_mode = 1'b0;
    logic [7:0] slave_byte = 8'h00;

    assign i_TX_Ready = model_rdy & ~block_rdy;
    assign i_RX_En    = model_rx_en | man_rx_en;
    assign i_RX_Count = man_rx_en ? man_cnt : model_cnt;
    assign i_RX_Byte  = man_rx_en ? man_byte : model_byte;

    spi_reg_access #(.TIMEOUT_CLKS(TO), .DUMMY_BYTE(8'h00), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_Req_Valid(i_Req_Valid), .i_Req_RW(i_Req_RW), .i_Req_Addr(i_Req_Addr),
        .i_Req_WData(i_Req_WData), .o_Req_Ready(o_Req_Ready),
        .o_Resp_Valid(o_Resp_Valid), .o_Resp_RData(o_Resp_RData), .o_Resp_Err(o_Resp_Err),
        .o_TX_Count(o_TX_Count), .o_TX_Byte(o_TX_Byte), .o_TX_En(o_TX_En),
        .i_TX_Ready(i_TX_Ready), .i_RX_Count(i_RX_Count), .i_RX_Byte(i_RX_Byte),
        .i_RX_En(i_RX_En)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_miss = 0, cyc = 0;
    int tx_total = 0, resp_total = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic       err_q[$];
    int         rcyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: TX pulse rules and response capture, sampled mid-cycle
    logic prev_en = 1'b0, prev_rdy = 1'b1;
    always @(negedge clk) begin
        if (rst_n && o_TX_En) begin
            tx_q.push_back(o_TX_Byte);
            tx_total++;
            check("tx_count", 32'(o_TX_Count), 32'd2);
            check("tx_consec", 32'(prev_en), 32'd0);
            check("tx_when_ready", 32'(prev_rdy), 32'd1);
        end
        if (rst_n && o_Resp_Valid) begin
            rd_q.push_back(o_Resp_RData);
            err_q.push_back(o_Resp_Err);
            rcyc_q.push_back(cyc);
            resp_total++;
        end
        prev_en  = o_TX_En;
        prev_rdy = i_TX_Ready;
    end

    // SPI master/slave model: busy for a few cycles per byte, then reports RX
    initial begin
        int idx = 0;
        logic [7:0] last_b0 = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (model_en && rst_n && o_TX_En) begin
                if (idx == 0) last_b0 = o_TX_Byte;
                model_rdy = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                model_rx_en = 1'b1;
                model_cnt   = 2'(idx);
                model_byte  = (idx == 0) ? 8'hFF : (echo_mode ? (last_b0 ^ 8'hC3) : slave_byte);
                @(posedge clk); #1;
                model_rx_en = 1'b0;
                model_rdy   = 1'b1;
                idx = (idx == 1) ? 0 : idx + 1;
            end
        end
    end

    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d, output int acc);
        int n = 0;
        acc = 0;
        @(negedge clk);
        while (!o_Req_Ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_Req_Ready) begin
            check("ready_wait", 32'(o_Req_Ready), 32'd1);
        end else begin
            i_Req_Valid = 1'b1; i_Req_RW = rw; i_Req_Addr = a; i_Req_WData = d;
            @(posedge clk); #1;
            acc = cyc;
            i_Req_Valid = 1'b0;
        end
    endtask

    task automatic wait_resp(input int want);
        int n = 0;
        while (resp_total < want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resp_wait", 32'(resp_total >= want), 32'd1);
    endtask

    task automatic wait_tx(input int want);
        int n = 0;
        while (tx_total < want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_wait", 32'(tx_total >= want), 32'd1);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] slave;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc, rb, tb0;

        vecs[0] = '{1'b0, 7'h15, 8'hA5, 8'h5A, 8'h15, 8'hA5, 8'h5A};
        vecs[1] = '{1'b1, 7'h03, 8'h77, 8'h3C, 8'h83, 8'h00, 8'h3C};
        vecs[2] = '{1'b0, 7'h7F, 8'h00, 8'h81, 8'h7F, 8'h00, 8'h81};
        vecs[3] = '{1'b1, 7'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{1'b1, 7'h00, 8'h12, 8'h00, 8'h80, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_Req_Ready), 32'd1);
        check("rst_resp_valid", 32'(o_Resp_Valid), 32'd0);
        check("rst_tx_en", 32'(o_TX_En), 32'd0);
        check("rst_tx_byte", 32'(o_TX_Byte), 32'd0);
        check("rst_tx_count", 32'(o_TX_Count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(o_Req_Ready), 32'd1);
        check("rel_rdata", 32'(o_Resp_RData), 32'd0);
        check("rel_err", 32'(o_Resp_Err), 32'd0);

        // Directed read/write vectors
        for (int i = 0; i < 5; i++) begin
            slave_byte = vecs[i].slave;
            tx_q.delete();
            rb = resp_total; tb0 = tx_total;
            issue(vecs[i].rw, vecs[i].addr, vecs[i].wdata, acc);
            wait_resp(rb + 1);
            repeat (4) @(negedge clk);
            check("tx_pulses", 32'(tx_total - tb0), 32'd2);
            check("resp_count", 32'(resp_total - rb), 32'd1);
            if (tx_q.size() >= 2) begin
                check("byte0", 32'(tx_q[0]), 32'(vecs[i].exp_b0));
                check("byte1", 32'(tx_q[1]), 32'(vecs[i].exp_b1));
            end
            if (rd_q.size() > rb) begin
                check("rdata", 32'(rd_q[rb]), 32'(vecs[i].exp_rdata));
                check("err", 32'(err_q[rb]), 32'd0);
                $display("vec %0d rw=%0d addr=%02h -> rdata=%02h err=%0d", i,
                         vecs[i].rw, vecs[i].addr, rd_q[rb], err_q[rb]);
            end
        end

        // Timeout with the SPI master never ready
        @(posedge clk); #1;
        block_rdy = 1'b1;
        rb = resp_total; tb0 = tx_total;
        issue(1'b0, 7'h22, 8'h44, acc);
        wait_resp(rb + 1);
        if (rd_q.size() > rb) begin
            check("to_latency", 32'(rcyc_q[rb] - acc), 32'd16);
            check("to_err", 32'(err_q[rb]), 32'd1);
            check("to_rdata", 32'(rd_q[rb]), 32'd0);
            $display("timeout: latency=%0d err=%0d rdata=%02h", rcyc_q[rb] - acc, err_q[rb], rd_q[rb]);
        end
        check("to_no_tx", 32'(tx_total - tb0), 32'd0);
        @(posedge clk); #1;
        block_rdy = 1'b0;

        // Capture on the last timeout cycle wins; an earlier slot-0 byte is ignored
        model_en = 1'b0;
        rb = resp_total; tb0 = tx_total;
        issue(1'b1, 7'h44, 8'h00, acc);
        repeat (8) @(posedge clk);
        #1; man_rx_en = 1'b1; man_cnt = 2'd0; man_byte = 8'h11;
        @(posedge clk); #1; man_rx_en = 1'b0;
        repeat (6) @(posedge clk);
        #1; man_rx_en = 1'b1; man_cnt = 2'd1; man_byte = 8'hE7;
        @(posedge clk); #1; man_rx_en = 1'b0;
        wait_resp(rb + 1);
        if (rd_q.size() > rb) begin
            check("tie_latency", 32'(rcyc_q[rb] - acc), 32'd16);
            check("tie_err", 32'(err_q[rb]), 32'd0);
            check("tie_rdata", 32'(rd_q[rb]), 32'hE7);
            $display("tie: latency=%0d err=%0d rdata=%02h", rcyc_q[rb] - acc, err_q[rb], rd_q[rb]);
        end
        check("tie_tx", 32'(tx_total - tb0), 32'd2);
        model_en = 1'b1;

        // Busy drop: request during WAIT_RX is neither accepted nor queued
        slave_byte = 8'h99;
        rb = resp_total; tb0 = tx_total;
        issue(1'b1, 7'h05, 8'h00, acc);
        wait_tx(tb0 + 2);
        i_Req_Valid = 1'b1; i_Req_RW = 1'b0; i_Req_Addr = 7'h66; i_Req_WData = 8'h33;
        repeat (2) @(negedge clk);
        i_Req_Valid = 1'b0;
        wait_resp(rb + 1);
        repeat (20) @(negedge clk);
        check("busy_resp", 32'(resp_total - rb), 32'd1);
        check("busy_tx", 32'(tx_total - tb0), 32'd2);
        if (rd_q.size() > rb) begin
            check("busy_rdata", 32'(rd_q[rb]), 32'h99);
            $display("busy drop: responses=%0d rdata=%02h", resp_total - rb, rd_q[rb]);
        end

        // Reset in WAIT_RX
        slave_byte = 8'h55;
        rb = resp_total; tb0 = tx_total;
        issue(1'b1, 7'h09, 8'h00, acc);
        wait_tx(tb0 + 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_en", 32'(o_TX_En), 32'd0);
        check("mid_rst_tx_byte", 32'(o_TX_Byte), 32'd0);
        check("mid_rst_tx_count", 32'(o_TX_Count), 32'd0);
        check("mid_rst_resp_valid", 32'(o_Resp_Valid), 32'd0);
        check("mid_rst_rdata", 32'(o_Resp_RData), 32'd0);
        check("mid_rst_err", 32'(o_Resp_Err), 32'd0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(o_Req_Ready), 32'd1);
        check("post_rst_no_resp", 32'(resp_total - rb), 32'd0);
        $display("reset mid-frame: responses=%0d", resp_total - rb);
        slave_byte = 8'h77;
        tx_q.delete();
        rb = resp_total;
        issue(1'b1, 7'h11, 8'h00, acc);
        wait_resp(rb + 1);
        repeat (4) @(negedge clk);
        if (tx_q.size() >= 2) begin
            check("post_rst_b0", 32'(tx_q[0]), 32'h91);
            check("post_rst_b1", 32'(tx_q[1]), 32'h00);
        end
        if (rd_q.size() > rb) begin
            check("post_rst_rdata", 32'(rd_q[rb]), 32'h77);
            check("post_rst_err", 32'(err_q[rb]), 32'd0);
            $display("after reset read: rdata=%02h err=%0d", rd_q[rb], err_q[rb]);
        end

        // Back-to-back: slave echoes byte0 ^ C3 so each response is distinguishable
        echo_mode = 1'b1;
        tx_q.delete();
        rb = resp_total; tb0 = tx_total;
        issue(1'b0, 7'h01, 8'hAA, acc);
        issue(1'b1, 7'h02, 8'hBB, acc);
        issue(1'b0, 7'h7E, 8'hCC, acc);
        wait_resp(rb + 3);
        repeat (4) @(negedge clk);
        check("b2b_resp", 32'(resp_total - rb), 32'd3);
        check("b2b_tx", 32'(tx_total - tb0), 32'd6);
        if (tx_q.size() >= 6) begin
            check("b2b_f0", {16'h0, tx_q[0], tx_q[1]}, 32'h01AA);
            check("b2b_f1", {16'h0, tx_q[2], tx_q[3]}, 32'h8200);
            check("b2b_f2", {16'h0, tx_q[4], tx_q[5]}, 32'h7ECC);
        end
        if (rd_q.size() >= rb + 3) begin
            check("b2b_r0", 32'(rd_q[rb]), 32'hC2);
            check("b2b_r1", 32'(rd_q[rb + 1]), 32'h41);
            check("b2b_r2", 32'(rd_q[rb + 2]), 32'hBD);
            $display("back-to-back: rdata=%02h %02h %02h", rd_q[rb], rd_q[rb + 1], rd_q[rb + 2]);
        end
        echo_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_reg_access.md
SPI_REG_ACCESS -- requirements
Module: spi_reg_access

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 1024: max clocks from request accept to read-byte capture before abort.
REQ-002 Parameter DUMMY_BYTE, default 8'h00: byte sent in data phase of a read.
REQ-003 Parameter CNT_W, default 2: width of SPI master byte-count ports (matches a 3-byte-per-CS master).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_Req_Valid  input  1  host request strobe.
REQ-007 i_Req_RW  input  1  1 = read, 0 = write.
REQ-008 i_Req_Addr  input  7  register address.
REQ-009 i_Req_WData  input  8  write data.
REQ-010 o_Req_Ready  output  1  block accepts a request this cycle.
REQ-011 o_Resp_Valid  output  1  one-cycle completion pulse.
REQ-012 o_Resp_RData  output  8  read data, valid with o_Resp_Valid.
REQ-013 o_Resp_Err  output  1  timeout flag, valid with o_Resp_Valid.
REQ-014 o_TX_Count  output  CNT_W  bytes per CS frame, to SPI master.
REQ-015 o_TX_Byte  output  8  byte to SPI master.
REQ-016 o_TX_En  output  1  one-cycle transmit pulse to SPI master.
REQ-017 i_TX_Ready  input  1  SPI master ready for next byte.
REQ-018 i_RX_Count  input  CNT_W  index of byte being received within current CS frame.
REQ-019 i_RX_Byte  input  8  received byte.
REQ-020 i_RX_En  input  1  received-byte pulse.

Function
REQ-021 Every transaction SHALL be one 2-byte CS frame: byte0 = {i_Req_RW, i_Req_Addr}, byte1 = i_Req_WData (write) or DUMMY_BYTE (read).
REQ-022 FSM states SHALL be IDLE, SEND_CMD, HOLD, SEND_DATA, WAIT_RX, DONE; all outputs registered.
REQ-023 IDLE: o_Req_Ready=1; on i_Req_Valid latch RW/Addr/WData, clear timeout counter, go SEND_CMD; o_Req_Ready=0 in all other states.
REQ-024 SEND_CMD: when i_TX_Ready=1, assert o_TX_En for exactly one cycle with o_TX_Byte=byte0, o_TX_Count=2, go HOLD.
REQ-025 HOLD: one cycle, i_TX_Ready ignored, then SEND_DATA.
REQ-026 SEND_DATA: when i_TX_Ready=1, pulse o_TX_En one cycle with o_TX_Byte=byte1, go WAIT_RX.
REQ-027 WAIT_RX: on i_RX_En=1 with i_RX_Count=1, capture i_RX_Byte into o_Resp_RData, go DONE; i_RX_En with i_RX_Count=0 SHALL be ignored.
REQ-028 For writes, the captured byte SHALL still be returned in o_Resp_RData (slave echo), o_Resp_Err=0.
REQ-029 DONE: o_Resp_Valid=1 for exactly one cycle, then IDLE; earliest next accept is the cycle after o_Resp_Valid.
REQ-030 Timeout counter SHALL increment every cycle in SEND_CMD, HOLD, SEND_DATA, WAIT_RX, saturating; when it equals TIMEOUT_CLKS-1 and no capture occurs that cycle, go DONE with o_Resp_Err=1, o_Resp_RData=8'h00, o_TX_En=0.
REQ-031 Capture and timeout in same cycle: capture wins, o_Resp_Err=0.
REQ-032 i_Req_Valid while o_Req_Ready=0 SHALL be ignored and not queued.
REQ-033 o_TX_En SHALL never be asserted in two consecutive cycles nor when i_TX_Ready=0.
REQ-034 o_TX_Byte and o_TX_Count SHALL hold their values between pulses; o_TX_Count SHALL be 2 whenever o_TX_En=1.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, o_Req_Ready=1 on release, o_Resp_Valid=0, o_Resp_RData=0, o_Resp_Err=0, o_TX_En=0, o_TX_Byte=0, o_TX_Count=0, timeout counter=0.
REQ-036 Reset mid-transaction SHALL abort with no o_Resp_Valid; first request after release proceeds normally.

Verification
REQ-037 Write: RW=0, Addr=7'h15, WData=8'hA5 with SPI model -> bytes 8'h15 then 8'hA5, o_TX_Count=2, one o_Resp_Valid, Err=0.
REQ-038 Read: RW=1, Addr=7'h03, slave returns 8'h3C on byte1 -> bytes 8'h83, 8'h00; o_Resp_RData=8'h3C, Err=0; RX byte0 value 8'hFF not captured.
REQ-039 Timeout: TIMEOUT_CLKS=16, i_TX_Ready held 0 -> o_Resp_Valid with Err=1, RData=0 exactly 16 cycles after accept, no o_TX_En.
REQ-040 Busy drop: second i_Req_Valid during WAIT_RX -> ignored, exactly one response, no extra o_TX_En.
REQ-041 Reset in WAIT_RX -> all outputs at reset values immediately, no response; next read completes correctly.
REQ-042 Back-to-back: three requests issued as soon as o_Req_Ready -> three frames, three responses in order, o_TX_En never consecutive.
